multicore_feeder: RTL and testbench

MULTICORE_FEEDER -- requirements
Module: multicore_feeder

---
 rtl/rede_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 42 ++++
 rtl/multicore_feeder.sv | 105 ++++++++++
 tb/tb_multicore_feeder.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/rede_pkg.sv
// Shared sizing constants and FSM state type for the multicore feeder.
package rede_pkg;

  localparam int N_CORES = 24;
  localparam int DW      = 31;
  localparam int REQW    = 4;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    GAP
  } feeder_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant, priority starts at the core after the last accepted winner.
module rr_arbiter #(
  parameter int N = 24
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         accept,
  output logic [N-1:0] gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] win;
  logic [PW:0]   idx;

  // Scan from the farthest offset down so the closest requester to ptr wins last.
  always_comb begin
    gnt = '0;
    win = '0;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = {1'b0, ptr} + (PW+1)'(i);
      if (idx >= (PW+1)'(N)) idx = idx - (PW+1)'(N);
      if (req[idx[PW-1:0]]) begin
        gnt = '0;
        gnt[idx[PW-1:0]] = 1'b1;
        win = idx[PW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (accept && (|req)) begin
      ptr <= (win == PW'(N - 1)) ? '0 : win + 1'b1;
    end
  end

endmodule

// File: rtl/multicore_feeder.sv
// Broadcasts host-written channel samples to requesting cores, one round-robin grant per three cycles.
module multicore_feeder #(
  parameter int N_CORES = rede_pkg::N_CORES,
  parameter int DW      = rede_pkg::DW,
  parameter int REQW    = rede_pkg::REQW
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_CORES*REQW-1:0]   req_flat,
  input  logic                      wr_en,
  input  logic [REQW-1:0]           wr_addr,
  input  logic signed [DW-1:0]      wr_data,
  input  logic                      clr,
  output logic signed [DW-1:0]      io_in,
  output logic [N_CORES-1:0]        gnt,
  output logic                      busy,
  output logic [15:0]               gnt_cnt
);

  import rede_pkg::*;

  localparam int NCH = 2 ** REQW;

  feeder_state_t         state;
  logic [REQW-1:0]       req_arr [N_CORES];
  logic [N_CORES-1:0]    req_nz;
  logic [N_CORES-1:0]    eligible;
  logic [N_CORES-1:0]    arb_gnt;
  logic [N_CORES-1:0]    last_win;
  logic [REQW-1:0]       sel_ch;
  logic                  accept;
  logic [NCH-1:0]        ch_valid;
  logic signed [DW-1:0]  ch_data [NCH];

  // Entry 0 is never written, so its valid bit stays clear and channel 0 can never be eligible.
  always_comb begin
    sel_ch = '0;
    for (int k = 0; k < N_CORES; k++) begin
      req_arr[k]  = req_flat[k*REQW +: REQW];
      req_nz[k]   = |req_arr[k];
      eligible[k] = req_nz[k] && ch_valid[req_arr[k]] && !((state == GAP) && last_win[k]);
      if (arb_gnt[k]) sel_ch = sel_ch | req_arr[k];
    end
  end

  assign accept = (state == IDLE) && (|eligible);
  assign busy   = |(req_nz & ~gnt);

  rr_arbiter #(.N(N_CORES)) u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (eligible),
    .accept (accept),
    .gnt    (arb_gnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_valid <= '0;
    end else if (clr) begin
      ch_valid <= '0;
    end else if (wr_en && (wr_addr != '0)) begin
      ch_valid[wr_addr] <= 1'b1;
    end
  end

  // Sample storage is deliberately not reset; only the valid flags gate its use.
  always_ff @(posedge clk) begin
    if (wr_en && (wr_addr != '0)) ch_data[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= '0;
      io_in    <= '0;
      gnt_cnt  <= '0;
      last_win <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|eligible) begin
            state    <= GRANT;
            gnt      <= arb_gnt;
            last_win <= arb_gnt;
            io_in    <= ch_data[sel_ch];
          end
        end
        GRANT: begin
          state <= GAP;
          gnt   <= '0;
          if (gnt_cnt != 16'hFFFF) gnt_cnt <= gnt_cnt + 16'd1;
        end
        GAP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          gnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicore_feeder.sv
// Directed self-checking bench for multicore_feeder: grants, round-robin order, stalls, reset, saturation.
module tb_multicore_feeder;

  localparam int NC = 24;
  localparam int DW = 31;
  localparam int RW = 4;

  logic                  clk;
  logic                  rst_n;
  logic [NC*RW-1:0]      req_flat;
  logic                  wr_en;
  logic [RW-1:0]         wr_addr;
  logic signed [DW-1:0]  wr_data;
  logic                  clr;
  logic signed [DW-1:0]  io_in;
  logic [NC-1:0]         gnt;
  logic                  busy;
  logic [15:0]           gnt_cnt;

  int checks = 0;
  int errors = 0;

  multicore_feeder #(.N_CORES(NC), .DW(DW), .REQW(RW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_flat (req_flat),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .clr      (clr),
    .io_in    (io_in),
    .gnt      (gnt),
    .busy     (busy),
    .gnt_cnt  (gnt_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_req(input int core, input logic [RW-1:0] ch);
    req_flat[core*RW +: RW] = ch;
  endtask

  task automatic write_ch(input logic [RW-1:0] addr, input logic signed [DW-1:0] data);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = addr; wr_data = data;
    @(negedge clk);
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
  endtask

  task automatic settle();
    req_flat = '0;
    repeat (4) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (gnt !== '0) begin errors++; $display("FAIL reset_gnt got=%h exp=0", gnt); end
    checks++; if (io_in !== '0) begin errors++; $display("FAIL reset_io_in got=%0d exp=0", io_in); end
    checks++; if (gnt_cnt !== 16'd0) begin errors++; $display("FAIL reset_gnt_cnt got=%0d exp=0", gnt_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_grant();
    write_ch(4'd3, -31'sd5);
    set_req(7, 4'd3);
    @(negedge clk);
    checks++; if (gnt !== (24'd1 << 7)) begin errors++; $display("FAIL single_gnt got=%h exp=%h", gnt, 24'd1 << 7); end
    checks++; if (io_in !== -31'sd5) begin errors++; $display("FAIL single_io_in got=%0d exp=-5", io_in); end
    set_req(7, 4'd0);
    @(negedge clk);
    checks++; if (gnt !== '0) begin errors++; $display("FAIL single_gap_gnt got=%h exp=0", gnt); end
    checks++; if (gnt_cnt !== 16'd1) begin errors++; $display("FAIL single_gnt_cnt got=%0d exp=1", gnt_cnt); end
    settle();
  endtask

  task automatic test_round_robin();
    int order [3] = '{0, 5, 23};
    logic signed [DW-1:0] vals [3] = '{31'sd10, 31'sd20, 31'sd30};
    int cyc;
    do_reset();
    write_ch(4'd1, 31'sd10);
    write_ch(4'd2, 31'sd20);
    write_ch(4'd3, 31'sd30);
    set_req(0, 4'd1); set_req(5, 4'd2); set_req(23, 4'd3);
    for (int g = 0; g < 3; g++) begin
      cyc = 0;
      do begin @(negedge clk); cyc++; end while (gnt === '0 && cyc < 10);
      checks++; if (gnt !== (24'd1 << order[g])) begin errors++; $display("FAIL rr_order%0d got=%h exp=%h", g, gnt, 24'd1 << order[g]); end
      checks++; if (io_in !== vals[g]) begin errors++; $display("FAIL rr_data%0d got=%0d exp=%0d", g, io_in, vals[g]); end
      checks++; if (cyc !== ((g == 0) ? 1 : 3)) begin errors++; $display("FAIL rr_spacing%0d got=%0d exp=%0d", g, cyc, (g == 0) ? 1 : 3); end
      set_req(order[g], 4'd0);
    end
    settle();
    set_req(23, 4'd3); set_req(5, 4'd2); set_req(0, 4'd1);
    @(negedge clk);
    checks++; if (gnt !== 24'd1) begin errors++; $display("FAIL rr_wrap got=%h exp=000001", gnt); end
    settle();
  endtask

  task automatic test_invalid_stall();
    int cyc;
    int bad = 0;
    set_req(2, 4'd9);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (gnt !== '0 || busy !== 1'b1) begin
        errors++; bad++;
        if (bad < 4) $display("FAIL stall_cycle%0d gnt=%h busy=%b exp gnt=0 busy=1", i, gnt, busy);
      end
    end
    write_ch(4'd9, 31'sd100);
    cyc = 0;
    while (gnt === '0 && cyc < 6) begin @(negedge clk); cyc++; end
    checks++; if (gnt !== (24'd1 << 2)) begin errors++; $display("FAIL stall_release_gnt got=%h exp=%h", gnt, 24'd1 << 2); end
    checks++; if (io_in !== 31'sd100) begin errors++; $display("FAIL stall_release_io_in got=%0d exp=100", io_in); end
    settle();
  endtask

  task automatic test_hold_through_gap();
    int cyc = 0;
    write_ch(4'd4, 31'sd44);
    set_req(4, 4'd4);
    while (gnt === '0 && cyc < 6) begin @(negedge clk); cyc++; end
    checks++; if (gnt !== (24'd1 << 4)) begin errors++; $display("FAIL hold_first got=%h exp=%h", gnt, 24'd1 << 4); end
    @(negedge clk);
    checks++; if (gnt !== '0) begin errors++; $display("FAIL hold_gap got=%h exp=0", gnt); end
    @(negedge clk);
    checks++; if (gnt !== '0) begin errors++; $display("FAIL hold_idle got=%h exp=0", gnt); end
    @(negedge clk);
    checks++; if (gnt !== (24'd1 << 4)) begin errors++; $display("FAIL hold_regrant got=%h exp=%h", gnt, 24'd1 << 4); end
    settle();
  endtask

  task automatic test_reset_mid_grant();
    int cyc = 0;
    set_req(1, 4'd4);
    while (gnt === '0 && cyc < 6) begin @(negedge clk); cyc++; end
    checks++; if (gnt !== (24'd1 << 1)) begin errors++; $display("FAIL midrst_pre got=%h exp=%h", gnt, 24'd1 << 1); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (gnt !== '0) begin errors++; $display("FAIL midrst_gnt got=%h exp=0", gnt); end
    checks++; if (gnt_cnt !== 16'd0) begin errors++; $display("FAIL midrst_cnt got=%0d exp=0", gnt_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (gnt !== '0 || busy !== 1'b1) begin errors++; $display("FAIL midrst_stall%0d gnt=%h busy=%b exp gnt=0 busy=1", i, gnt, busy); end
    end
    settle();
  endtask

  task automatic test_saturation();
    int grants = 0;
    int cyc = 0;
    write_ch(4'd5, 31'sd7);
    @(negedge clk);
    force dut.gnt_cnt = 16'hFFF0;
    @(negedge clk);
    release dut.gnt_cnt;
    @(negedge clk);
    checks++; if (gnt_cnt !== 16'hFFF0) begin errors++; $display("FAIL sat_preload got=%h exp=fff0", gnt_cnt); end
    set_req(6, 4'd5);
    while (grants < 30 && cyc < 200) begin
      @(negedge clk); cyc++;
      if (gnt !== '0) grants++;
    end
    repeat (2) @(negedge clk);
    checks++; if (grants !== 30) begin errors++; $display("FAIL sat_grants got=%0d exp=30", grants); end
    checks++; if (gnt_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_value got=%h exp=ffff", gnt_cnt); end
    repeat (9) @(negedge clk);
    checks++; if (gnt_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got=%h exp=ffff", gnt_cnt); end
    settle();
  endtask

  task automatic test_clear();
    write_ch(4'd6, 31'sd66);
    @(negedge clk);
    clr = 1'b1; wr_en = 1'b1; wr_addr = 4'd7; wr_data = 31'sd77;
    @(negedge clk);
    clr = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    set_req(8, 4'd6); set_req(9, 4'd7);
    repeat (3) @(negedge clk);
    checks++; if (gnt !== '0 || busy !== 1'b1) begin errors++; $display("FAIL clr_stall gnt=%h busy=%b exp gnt=0 busy=1", gnt, busy); end
    settle();
  endtask

  initial begin
    rst_n = 1'b1; req_flat = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; clr = 1'b0;
    test_reset();
    test_single_grant();
    test_round_robin();
    test_invalid_stall();
    test_hold_through_gap();
    test_reset_mid_grant();
    test_saturation();
    test_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
